aes_128_axil_regs: RTL
======================

// Module: aes_128_axil_regs
// PURPOSE
// - AXI4-Lite slave register file directly upstream of the AES-128 encryption core: the bus master loads key and plaintext, starts the core and reads back ciphertext.
// - Drives the core's start/key/plaintext inputs; captures its done/ciphertext outputs; raises a level interrupt.
// PARAMETERS
// - C_S_AXI_DATA_WIDTH  32  bus data width; only 32 supported
// - C_S_AXI_ADDR_WIDTH  7   byte address width; covers 0x00-0x3C
// PORTS
// - s00_axi_aclk     in   1    single clock for bus and core side
// - s00_axi_aresetn  in   1    asynchronous, active-low reset
// - s00_axi_awaddr/awprot/awvalid in 7/3/1 ; awready out 1 : write address channel
// - s00_axi_wdata/wstrb/wvalid in 32/4/1 ; wready out 1 : write data channel
// - s00_axi_bresp out 2 ; bvalid out 1 ; bready in 1 : write response channel
// - s00_axi_araddr/arprot/arvalid in 7/3/1 ; arready out 1 : read address channel
// - s00_axi_rdata out 32 ; rresp out 2 ; rvalid out 1 ; rready in 1 : read data channel
// - core_start       out  1    one-cycle start pulse to AES core
// - core_key         out  128  key; word KEY0 = bits [127:96]
// - core_pt          out  128  plaintext; word PT0 = bits [127:96]
// - core_done        in   1    one-cycle pulse from core, ciphertext valid
// - core_ct          in   128  ciphertext, sampled on core_done
// - irq              out  1    level: STATUS.done & CTRL.irq_en
// BEHAVIOUR
// - Reset: all ready/valid outputs 0, bresp/rresp 0, rdata 0, core_start 0, all registers 0, irq 0.
// - Map: 0x00 CTRL (b0 start W1 self-clear, reads 0; b1 irq_en RW); 0x04 STATUS (b0 busy RO; b1 done sticky, W1C);
//   0x10-0x1C KEY0-3 RW; 0x20-0x2C PT0-3 RW; 0x30-0x3C CT0-3 RO; other offsets read 0, writes dropped, resp OKAY.
// - Write: AW and W accepted independently (awready/wready each high 1 cycle on valid while no addr/data held);
//   register updated the cycle after both are held, bvalid asserted same cycle, held until bready. No new AW/W while bvalid.
// - wstrb honoured per byte on RW registers; CTRL/STATUS act only if wstrb[0].
// - Read: arready pulses 1 cycle when arvalid & !rvalid; rdata/rvalid registered next cycle; held until rready.
// - Latency: write 2 cycles AW/W->bvalid min; read 1 cycle AR accept->rvalid.
// - States (core side): IDLE -> BUSY on CTRL.start write (core_start=1 for exactly that next cycle, busy=1, done cleared);
//   BUSY -> IDLE on core_done (CT0-3 <= core_ct, busy=0, done=1).
// - Start while BUSY: ignored, bresp OKAY. KEY/PT write while BUSY: dropped, bresp SLVERR (2'b10).
// - core_done and STATUS W1C same cycle: done set wins. core_done while IDLE: ignored.
// - CT readable anytime; holds last result until next core_done.
// - Reset mid-operation: busy/done/CT cleared immediately; a late core_done after reset deasserts is ignored (IDLE).
// - awprot/arprot unused.
// STRUCTURE
// - Shared package aes_128_pkg: offset localparams (CTRL/STATUS/KEY0/PT0/CT0), CTRL/STATUS bit indices,
//   resp codes (OKAY/SLVERR), typedef aes_block_t = logic [127:0].
// - Single module, no sub-modules; core instantiated by the parent, not here.
// TESTING
// - Reset: hold aresetn low 100 ns -> all outputs 0, reads of 0x00-0x3C return 0.
// - RW: write 0x01..0x04 to 0x10-0x1C, 0xA..0xD to 0x20-0x2C -> readback equal; core_key=128'h00000001_00000002_00000003_00000004.
// - FIPS-197 flow with core model: key 000102..0f, pt 00112233..ff, write CTRL=1 -> one core_start pulse, STATUS=1;
//   after core_done, STATUS=2, CT=69c4e0d8_6a7b0430_d8cdb780_70b4c55a.
// - Busy guard: start, then write PT0 while busy -> bresp SLVERR, PT0 unchanged; second start ignored (one pulse only).
// - IRQ/W1C: CTRL=2, complete op -> irq=1; write STATUS=2 -> irq=0, STATUS=0; core_done coincident with W1C -> done stays 1.
// - Channel skew: W 3 cycles before AW, then bready held low 5 cycles -> single write, bvalid held stable; wstrb=4'b0001 updates byte 0 only.

Source files
------------

// File: rtl/aes_128_pkg.sv
// Shared definitions for the AES-128 AXI4-Lite register block: register map,
// bit positions, response codes and block/word types.
package aes_128_pkg;

    localparam int unsigned AXI_ADDR_W = 7;
    localparam int unsigned AXI_DATA_W = 32;

    localparam logic [6:0] CTRL_OFF   = 7'h00;
    localparam logic [6:0] STATUS_OFF = 7'h04;
    localparam logic [6:0] KEY0_OFF   = 7'h10;
    localparam logic [6:0] PT0_OFF    = 7'h20;
    localparam logic [6:0] CT0_OFF    = 7'h30;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [127:0] aes_block_t;
    // Word 3 holds bits [127:96], i.e. the register at the lowest offset.
    typedef logic [3:0][31:0] aes_words_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } core_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_128_axil_regs.sv
// AXI4-Lite register file in front of an AES-128 core: key/plaintext load,
// start control, ciphertext capture, sticky done status and level interrupt.
module aes_128_axil_regs
    import aes_128_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              core_start,
    output logic [127:0]                      core_key,
    output logic [127:0]                      core_pt,
    input  logic                              core_done,
    input  logic [127:0]                      core_ct,
    output logic                              irq
);

    logic        aw_held, w_held;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    core_state_e state_q, state_d;
    logic        done_q, done_d;
    logic        irq_en_q, irq_en_d;
    logic        start_d;
    aes_words_t  key_q, key_d, pt_q, pt_d, ct_q, ct_d;

    logic        wr_fire;
    logic [6:0]  wr_addr, rd_addr;
    logic [1:0]  bresp_d;
    logic [31:0] rdata_d;

    logic        unused;
    assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign wr_fire  = aw_held && w_held && !s00_axi_bvalid;
    assign wr_addr  = {waddr_q, 2'b00};
    assign rd_addr  = {s00_axi_araddr[6:2], 2'b00};
    assign core_key = key_q;
    assign core_pt  = pt_q;

    // Register updates and core-side state transitions.
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;
        start_d  = 1'b0;
        key_d    = key_q;
        pt_d     = pt_q;
        ct_d     = ct_q;
        bresp_d  = RESP_OKAY;
        if (wr_fire) begin
            if (wr_addr == CTRL_OFF && wstrb_q[0]) begin
                irq_en_d = wdata_q[CTRL_IRQ_EN];
                if (wdata_q[CTRL_START] && state_q == ST_IDLE) begin
                    state_d = ST_BUSY;
                    start_d = 1'b1;
                    done_d  = 1'b0;
                end
            end
            if (wr_addr == STATUS_OFF && wstrb_q[0] && wdata_q[STAT_DONE]) begin
                done_d = 1'b0;
            end
            if (wr_addr[6:4] == KEY0_OFF[6:4] || wr_addr[6:4] == PT0_OFF[6:4]) begin
                if (state_q == ST_BUSY) begin
                    bresp_d = RESP_SLVERR;
                end else if (wr_addr[6:4] == KEY0_OFF[6:4]) begin
                    key_d[~wr_addr[3:2]] = apply_wstrb(key_q[~wr_addr[3:2]], wdata_q, wstrb_q);
                end else begin
                    pt_d[~wr_addr[3:2]] = apply_wstrb(pt_q[~wr_addr[3:2]], wdata_q, wstrb_q);
                end
            end
        end
        // Completion has priority over a same-cycle done clear.
        if (state_q == ST_BUSY && core_done) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ct_d    = aes_words_t'(core_ct);
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd_addr == CTRL_OFF) begin
            rdata_d[CTRL_IRQ_EN] = irq_en_q;
        end else if (rd_addr == STATUS_OFF) begin
            rdata_d[STAT_DONE] = done_q;
            rdata_d[STAT_BUSY] = (state_q == ST_BUSY);
        end else if (rd_addr[6:4] == KEY0_OFF[6:4]) begin
            rdata_d = key_q[~rd_addr[3:2]];
        end else if (rd_addr[6:4] == PT0_OFF[6:4]) begin
            rdata_d = pt_q[~rd_addr[3:2]];
        end else if (rd_addr[6:4] == CT0_OFF[6:4]) begin
            rdata_d = ct_q[~rd_addr[3:2]];
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            core_start <= 1'b0;
            irq        <= 1'b0;
            key_q      <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            irq_en_q   <= irq_en_d;
            core_start <= start_d;
            irq        <= done_d && irq_en_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            ct_q       <= ct_d;
        end
    end

    // AXI4-Lite channel handshakes; ready signals are single-cycle pulses.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rresp   <= RESP_OKAY;
            s00_axi_rdata   <= '0;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            waddr_q         <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
        end else begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_arready <= 1'b0;
            if (!s00_axi_awready && s00_axi_awvalid && !aw_held && !s00_axi_bvalid) begin
                s00_axi_awready <= 1'b1;
            end
            if (s00_axi_awready && s00_axi_awvalid) begin
                aw_held <= 1'b1;
                waddr_q <= s00_axi_awaddr[6:2];
            end
            if (!s00_axi_wready && s00_axi_wvalid && !w_held && !s00_axi_bvalid) begin
                s00_axi_wready <= 1'b1;
            end
            if (s00_axi_wready && s00_axi_wvalid) begin
                w_held  <= 1'b1;
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            if (wr_fire) begin
                aw_held        <= 1'b0;
                w_held         <= 1'b0;
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= bresp_d;
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
            if (!s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid) begin
                s00_axi_arready <= 1'b1;
            end
            if (s00_axi_arready && s00_axi_arvalid) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rresp  <= RESP_OKAY;
                s00_axi_rdata  <= rdata_d;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule
